// File: rtl/pipo_write_arbiter.sv
// pipo_write_arbiter
// Round-robin arbiter that serialises writes from NREQ requesters into one
// shared PIPO register. Each transfer runs IDLE -> GRANT -> LOAD -> IDLE.
// In GRANT the winner is re-checked. If its request has gone, the transfer
// is aborted.
// Optional feature: define ARB_LOCK_EN to add the `lock` input. A locked
// winner can then do back-to-back loads of up to 4 in a row.
module pipo_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]         lock,
`endif
    output logic [NREQ-1:0]         gnt,
    output logic                    pipo_load,
    output logic [WIDTH-1:0]        pipo_data,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic [15:0]             wr_count
);

    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;
    logic          pick_valid;
    logic [IW-1:0] next_ptr;
`ifdef ARB_LOCK_EN
    logic [1:0]    burst_cnt;
`endif

    // Round-robin search: first active request at or after rr_ptr, wrapping at NREQ-1
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(rr_ptr) + i) % NREQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign next_ptr = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
    assign busy     = (state != IDLE);

    // Transfer sequencing, grant/load strobes, captured data and bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            pipo_load <= 1'b0;
            pipo_data <= '0;
            owner     <= '0;
            wr_count  <= '0;
            rr_ptr    <= '0;
            winner    <= '0;
`ifdef ARB_LOCK_EN
            burst_cnt <= '0;
`endif
        end else begin
            gnt       <= '0;
            pipo_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt    <= NREQ'(1) << pick_idx;
                        winner <= pick_idx;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (req[winner]) begin
                        pipo_data <= req_data[winner*WIDTH +: WIDTH];
                        pipo_load <= 1'b1;
                        state     <= LOAD;
                    end else begin
                        // Abort: the pointer is left alone so the same search repeats.
                        state <= IDLE;
`ifdef ARB_LOCK_EN
                        burst_cnt <= '0;
`endif
                    end
                end
                LOAD: begin
                    owner    <= winner;
                    wr_count <= wr_count + 16'd1;
`ifdef ARB_LOCK_EN
                    // A locked winner skips IDLE. The burst is capped at 4 loads.
                    if (lock[winner] && req[winner] && burst_cnt != 2'd3) begin
                        gnt       <= NREQ'(1) << winner;
                        burst_cnt <= burst_cnt + 2'd1;
                        state     <= GRANT;
                    end else begin
                        rr_ptr    <= next_ptr;
                        burst_cnt <= '0;
                        state     <= IDLE;
                    end
`else
                    rr_ptr <= next_ptr;
                    state  <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipo_write_arbiter.sv
// Testbench for pipo_write_arbiter (NREQ=4, WIDTH=8).
// Inputs are driven, then one clock edge is taken, then outputs are sampled 1 time unit after the edge.
module tb_pipo_write_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
`ifdef ARB_LOCK_EN
    logic [3:0]  lock;
`endif
    logic [3:0]  gnt;
    logic        pipo_load;
    logic [7:0]  pipo_data;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    pipo_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .pipo_load (pipo_load),
        .pipo_data (pipo_data),
        .owner     (owner),
        .busy      (busy),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic        load;
        logic [7:0]  data;
        logic [1:0]  owner;
        logic        busy;
        logic [15:0] count;
    } vec_t;

    vec_t vecs[14];

    // Reference model state: a transaction record with its age in cycles.
    int          m_rr;
    int          m_win;
    int          m_age;
    logic [15:0] m_cnt;
    int          m_owner;
    logic [7:0]  m_data;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic l,
                           input logic [7:0] d, input logic [1:0] o,
                           input logic b, input logic [15:0] c);
        chk({tag, " gnt"},       32'(gnt),       32'(g));
        chk({tag, " pipo_load"}, 32'(pipo_load), 32'(l));
        chk({tag, " pipo_data"}, 32'(pipo_data), 32'(d));
        chk({tag, " owner"},     32'(owner),     32'(o));
        chk({tag, " busy"},      32'(busy),      32'(b));
        chk({tag, " wr_count"},  32'(wr_count),  32'(c));
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req   = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic model_reset;
        m_rr = 0; m_win = 0; m_age = 0; m_cnt = '0; m_owner = 0; m_data = '0;
    endtask

    // Advance the model by one clock edge, using the inputs seen at that edge.
    task automatic model_step(input logic [3:0] r, input logic [31:0] d);
        if (m_age == 0) begin
            for (int i = 0; i < NREQ; i++) begin
                int c;
                c = (m_rr + i) % NREQ;
                if (m_age == 0 && r[c]) begin
                    m_win = c;
                    m_age = 1;
                end
            end
        end else if (m_age == 1) begin
            if (r[m_win]) begin
                m_data = d[m_win*8 +: 8];
                m_age  = 2;
            end else begin
                m_age = 0;
            end
        end else begin
            m_owner = m_win;
            m_cnt   = m_cnt + 16'd1;
            m_rr    = (m_win + 1) % NREQ;
            m_age   = 0;
        end
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] exp_g;
        logic       exp_l;

        reset    = 1'b1;
        req      = '0;
        req_data = '0;
`ifdef ARB_LOCK_EN
        lock     = '0;
`endif
        #2;
        chk_all("reset", 4'b0, 1'b0, 8'h00, 2'd0, 1'b0, 16'd0);
        tick;
        reset = 1'b0;

        // Single request, abort handling, and pointer behaviour
        vecs[0]  = '{4'b0010, 4'b0010, 1'b0, 8'h00, 2'd0, 1'b1, 16'd0};
        vecs[1]  = '{4'b0010, 4'b0000, 1'b1, 8'hA5, 2'd0, 1'b1, 16'd0};
        vecs[2]  = '{4'b0000, 4'b0000, 1'b0, 8'hA5, 2'd1, 1'b0, 16'd1};
        vecs[3]  = '{4'b0100, 4'b0100, 1'b0, 8'hA5, 2'd1, 1'b1, 16'd1};
        vecs[4]  = '{4'b0000, 4'b0000, 1'b0, 8'hA5, 2'd1, 1'b0, 16'd1};
        vecs[5]  = '{4'b1011, 4'b1000, 1'b0, 8'hA5, 2'd1, 1'b1, 16'd1};
        vecs[6]  = '{4'b1011, 4'b0000, 1'b1, 8'hD3, 2'd1, 1'b1, 16'd1};
        vecs[7]  = '{4'b1011, 4'b0000, 1'b0, 8'hD3, 2'd3, 1'b0, 16'd2};
        vecs[8]  = '{4'b1011, 4'b0001, 1'b0, 8'hD3, 2'd3, 1'b1, 16'd2};
        vecs[9]  = '{4'b0000, 4'b0000, 1'b0, 8'hD3, 2'd3, 1'b0, 16'd2};
        vecs[10] = '{4'b0011, 4'b0001, 1'b0, 8'hD3, 2'd3, 1'b1, 16'd2};
        vecs[11] = '{4'b0011, 4'b0000, 1'b1, 8'hB0, 2'd3, 1'b1, 16'd2};
        vecs[12] = '{4'b0011, 4'b0000, 1'b0, 8'hB0, 2'd0, 1'b0, 16'd3};
        vecs[13] = '{4'b0011, 4'b0010, 1'b0, 8'hB0, 2'd0, 1'b1, 16'd3};
        req_data = 32'hD3C2A5B0;
        for (int i = 0; i < 14; i++) begin
            req = vecs[i].req;
            tick;
            chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].load, vecs[i].data,
                    vecs[i].owner, vecs[i].busy, vecs[i].count);
        end

        // All four requesting continuously: a load every 3 cycles, in order 0,1,2,3,0
        do_reset;
        req      = 4'b1111;
        req_data = 32'h13121110;
        for (int k = 0; k < 15; k++) begin
            tick;
            exp_g = (k % 3 == 0) ? 4'(1 << ((k / 3) % 4)) : 4'b0;
            exp_l = (k % 3 == 1);
            chk($sformatf("rr%0d gnt", k), 32'(gnt), 32'(exp_g));
            chk($sformatf("rr%0d load", k), 32'(pipo_load), 32'(exp_l));
            if (exp_l)
                chk($sformatf("rr%0d data", k), 32'(pipo_data), 32'(8'h10 + (k / 3) % 4));
        end
        req = '0;
        tick;
        chk_all("rr_end", 4'b0, 1'b0, 8'h10, 2'd0, 1'b0, 16'd5);
        tick;

        // Asynchronous reset in GRANT: abandon the transfer immediately
        req = 4'b0100;
        tick;
        chk("pre_rst gnt", 32'(gnt), 32'(4'b0100));
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 4'b0, 1'b0, 8'h00, 2'd0, 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk($sformatf("post_rst%0d load", k), 32'(pipo_load), 32'd0);
            chk($sformatf("post_rst%0d busy", k), 32'(busy), 32'd0);
        end
        req      = 4'b1000;
        req_data = 32'h7E000000;
        tick;
        chk("req3 gnt", 32'(gnt), 32'(4'b1000));
        tick;
        chk("req3 load", 32'(pipo_load), 32'd1);
        chk("req3 data", 32'(pipo_data), 32'h7E);
        req = '0;
        tick;

        // wr_count wrap: preset to 0xFFFF, then one more load
        do_reset;
        req      = 4'b1001;
        req_data = 32'h000000C4;
        tick;
        chk("wrap favour0 gnt", 32'(gnt), 32'(4'b0001));
        tick;
        chk("wrap load", 32'(pipo_load), 32'd1);
        force dut.wr_count = 16'hFFFF;
        #1;
        release dut.wr_count;
        req = 4'b0000;
        tick;
        chk("wrap wr_count", 32'(wr_count), 32'd0);
        chk("wrap data hold", 32'(pipo_data), 32'hC4);

`ifdef ARB_LOCK_EN
        // Locked burst: requester 0 gets 4 loads 2 cycles apart, then requester 1 is granted
        do_reset;
        lock     = 4'b0001;
        req      = 4'b0011;
        req_data = 32'h0000B1B0;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (k < 8) begin
                chk($sformatf("lock%0d gnt", k), 32'(gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
                chk($sformatf("lock%0d load", k), 32'(pipo_load), 32'(k % 2 == 1));
            end
        end
        chk("lock next gnt", 32'(gnt), 32'(4'b0010));
        chk("lock wr_count", 32'(wr_count), 32'd4);
        lock = '0;
        req  = '0;
        tick;
        tick;
        tick;
`endif

        // Randomised traffic against the transaction-level model
        do_reset;
        model_reset;
        r = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0)
                r = 4'($urandom_range(0, 15));
            req      = r;
            req_data = $urandom;
            tick;
            model_step(req, req_data);
            chk_all($sformatf("rand%0d", c),
                    (m_age == 1) ? 4'(1 << m_win) : 4'b0,
                    (m_age == 2), m_data, 2'(m_owner), (m_age != 0), m_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
